// File: rtl/mbox_queue.sv
// Host/coprocessor mailbox: a 6502-side command FIFO with staged payload and an AVR-side reply buffer.
// Optional MBOX_REPLY_IRQ_EN adds an a_irq_en bit driving a_irq from reply_valid.
module mbox_queue #(
  parameter int DATA_BYTES = 2,
  parameter int CMDQ_DEPTH = 4
) (
  input  logic       C7M,
  input  logic       RES,
  input  logic [3:0] a_addr,
  input  logic       a_wr,
  input  logic       a_rd,
  input  logic [7:0] a_din,
  output logic [7:0] a_dout,
  input  logic [3:0] r_addr,
  input  logic       r_wr,
  input  logic       r_rd,
  input  logic [7:0] r_din,
  output logic [7:0] r_dout,
  output logic       avr_irq,
  output logic       a_irq,
  output logic       avr_rst
);

  localparam int CW    = $clog2(CMDQ_DEPTH + 1);
  localparam int PW    = $clog2(CMDQ_DEPTH);
  localparam int IW    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int PAY_W = 8 * DATA_BYTES;
  localparam int ENT_W = 7 + PAY_W;

  typedef logic [DATA_BYTES-1:0][7:0] payload_t;

  payload_t        staging_q, staging_d;
  payload_t        reply_q, reply_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            reply_valid_q, reply_valid_d;
  logic            avr_irq_en_q, avr_irq_en_d;
  logic            avr_rst_q, avr_rst_d;
  logic [7:0]      a_dout_q, a_dout_d;
  logic [7:0]      r_dout_q, r_dout_d;
  logic [ENT_W-1:0] mem_q [CMDQ_DEPTH];
`ifdef MBOX_REPLY_IRQ_EN
  logic            a_irq_en_q, a_irq_en_d;
`endif

  logic            empty, full, push, pop, do_push, do_pop;
  logic            a_data_sel, r_data_sel;
  logic [IW-1:0]   a_idx, r_idx;
  logic [ENT_W-1:0] head;
  logic [6:0]      head_cmd;
  payload_t        head_pay;
  logic [7:0]      a_rdata, r_rdata;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(CMDQ_DEPTH));
  assign push    = a_wr && (a_addr == 4'd1);
  assign pop     = r_wr && (r_addr == 4'd1);
  // A pop frees the slot a same-cycle push into a full queue needs; a pop on empty is dropped.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign a_data_sel = (a_addr >= 4'd2) && (a_addr < 4'(2 + DATA_BYTES));
  assign r_data_sel = (r_addr >= 4'd2) && (r_addr < 4'(2 + DATA_BYTES));
  assign a_idx      = IW'(a_addr - 4'd2);
  assign r_idx      = IW'(r_addr - 4'd2);

  assign head     = mem_q[rd_ptr_q];
  assign head_cmd = head[ENT_W-1 -: 7];
  assign head_pay = head[PAY_W-1:0];

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    a_rdata = 8'h00;
    if (a_addr == 4'd0)  a_rdata = {overflow_q, full, reply_valid_q, 5'(count_q)};
    else if (a_data_sel) a_rdata = reply_q[a_idx];

    r_rdata = 8'h00;
    if (r_addr == 4'd0)                r_rdata = {!empty, reply_valid_q, 1'b0, 5'(count_q)};
    else if (r_addr == 4'd1 && !empty) r_rdata = {1'b1, head_cmd};
    else if (r_data_sel && !empty)     r_rdata = head_pay[r_idx];
  end

  always_comb begin
    staging_d     = staging_q;
    reply_d       = reply_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    overflow_d    = overflow_q;
    reply_valid_d = reply_valid_q;
    avr_irq_en_d  = avr_irq_en_q;
    avr_rst_d     = avr_rst_q;
`ifdef MBOX_REPLY_IRQ_EN
    a_irq_en_d    = a_irq_en_q;
`endif

    if (a_wr && a_data_sel) staging_d[a_idx] = a_din;
    if (a_wr && a_addr == 4'd0) begin
      if (a_din[2]) overflow_d = 1'b0;
      avr_rst_d = a_din[0];
`ifdef MBOX_REPLY_IRQ_EN
      a_irq_en_d = a_din[1];
`endif
    end
    if (push && full && !do_pop) overflow_d = 1'b1;

    if (r_wr && r_data_sel) reply_d[r_idx] = r_din;
    if (r_wr && r_addr == 4'd0) avr_irq_en_d = r_din[0];

    // Post is applied after ack so a same-cycle post wins.
    if (a_wr && a_addr == 4'hE) reply_valid_d = 1'b0;
    if (r_wr && r_addr == 4'hF) reply_valid_d = 1'b1;

    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);

    a_dout_d = a_rd ? a_rdata : a_dout_q;
    r_dout_d = r_rd ? r_rdata : r_dout_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge C7M) begin
    if (RES) begin
      staging_q     <= '0;
      reply_q       <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      reply_valid_q <= 1'b0;
      avr_irq_en_q  <= 1'b0;
      avr_rst_q     <= 1'b0;
      a_dout_q      <= 8'h00;
      r_dout_q      <= 8'h00;
`ifdef MBOX_REPLY_IRQ_EN
      a_irq_en_q    <= 1'b0;
`endif
    end else begin
      staging_q     <= staging_d;
      reply_q       <= reply_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      overflow_q    <= overflow_d;
      reply_valid_q <= reply_valid_d;
      avr_irq_en_q  <= avr_irq_en_d;
      avr_rst_q     <= avr_rst_d;
      a_dout_q      <= a_dout_d;
      r_dout_q      <= r_dout_d;
`ifdef MBOX_REPLY_IRQ_EN
      a_irq_en_q    <= a_irq_en_d;
`endif
    end
  end

  // NOTE: FIFO storage is not reset; count/pointers define validity and empty head reads are masked.
  always_ff @(posedge C7M) begin
    if (do_push) mem_q[wr_ptr_q] <= {a_din[6:0], staging_q};
  end

  assign a_dout  = a_dout_q;
  assign r_dout  = r_dout_q;
  assign avr_rst = avr_rst_q;
  assign avr_irq = avr_irq_en_q & !empty;
`ifdef MBOX_REPLY_IRQ_EN
  assign a_irq   = a_irq_en_q & reply_valid_q;
`else
  assign a_irq   = 1'b0;
`endif

endmodule

// File: tb/tb_mbox_queue.sv
// Directed self-checking bench for mbox_queue with DATA_BYTES=2, CMDQ_DEPTH=4.
// Expected a_irq follows MBOX_REPLY_IRQ_EN as defined for the build.
module tb_mbox_queue;

`ifdef MBOX_REPLY_IRQ_EN
  localparam logic EXP_A_IRQ = 1'b1;
`else
  localparam logic EXP_A_IRQ = 1'b0;
`endif

  logic       C7M = 1'b0;
  logic       RES;
  logic [3:0] a_addr, r_addr;
  logic       a_wr, a_rd, r_wr, r_rd;
  logic [7:0] a_din, r_din;
  logic [7:0] a_dout, r_dout;
  logic       avr_irq, a_irq, avr_rst;

  int n_checks = 0;
  int n_pass   = 0;

  mbox_queue #(.DATA_BYTES(2), .CMDQ_DEPTH(4)) dut (
    .C7M(C7M), .RES(RES),
    .a_addr(a_addr), .a_wr(a_wr), .a_rd(a_rd), .a_din(a_din), .a_dout(a_dout),
    .r_addr(r_addr), .r_wr(r_wr), .r_rd(r_rd), .r_din(r_din), .r_dout(r_dout),
    .avr_irq(avr_irq), .a_irq(a_irq), .avr_rst(avr_rst)
  );

  always #5 C7M = ~C7M;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
  endtask

  // Strobes are driven on the falling edge and held for exactly one rising edge.
  task automatic a_write(input logic [3:0] addr, input logic [7:0] d);
    @(negedge C7M); a_addr = addr; a_din = d; a_wr = 1'b1;
    @(negedge C7M); a_wr = 1'b0;
  endtask

  task automatic r_write(input logic [3:0] addr, input logic [7:0] d);
    @(negedge C7M); r_addr = addr; r_din = d; r_wr = 1'b1;
    @(negedge C7M); r_wr = 1'b0;
  endtask

  task automatic a_read(input logic [3:0] addr, output logic [7:0] d);
    @(negedge C7M); a_addr = addr; a_rd = 1'b1;
    @(negedge C7M); a_rd = 1'b0; d = a_dout;
  endtask

  task automatic r_read(input logic [3:0] addr, output logic [7:0] d);
    @(negedge C7M); r_addr = addr; r_rd = 1'b1;
    @(negedge C7M); r_rd = 1'b0; d = r_dout;
  endtask

  task automatic push_pop(input logic [7:0] cmd);
    @(negedge C7M);
    a_addr = 4'd1; a_din = cmd; a_wr = 1'b1;
    r_addr = 4'd1; r_wr = 1'b1;
    @(negedge C7M); a_wr = 1'b0; r_wr = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    RES = 1'b1;
    a_addr = '0; r_addr = '0; a_din = '0; r_din = '0;
    a_wr = 1'b0; a_rd = 1'b0; r_wr = 1'b0; r_rd = 1'b0;
    repeat (3) @(negedge C7M);
    RES = 1'b0;

    // Reset state
    check("rst_a_dout", a_dout, 8'h00);
    check("rst_r_dout", r_dout, 8'h00);
    check("rst_avr_irq", {7'd0, avr_irq}, 8'h00);
    check("rst_a_irq", {7'd0, a_irq}, 8'h00);
    check("rst_avr_rst", {7'd0, avr_rst}, 8'h00);
    a_read(4'd0, rd); check("rst_a_status", rd, 8'h00);

    // Single command round trip
    r_write(4'd0, 8'h01);
    check("irq_en_empty", {7'd0, avr_irq}, 8'h00);
    a_write(4'd2, 8'h34);
    a_write(4'd3, 8'h12);
    a_write(4'd1, 8'h05);
    check("avr_irq_after_push", {7'd0, avr_irq}, 8'h01);
    r_read(4'd1, rd); check("head_cmd", rd, 8'h85);
    r_read(4'd2, rd); check("head_pay0", rd, 8'h34);
    r_read(4'd3, rd); check("head_pay1", rd, 8'h12);
    r_read(4'd0, rd); check("r_status_one", rd, 8'h81);
    r_write(4'd1, 8'h00);
    check("avr_irq_after_pop", {7'd0, avr_irq}, 8'h00);
    r_read(4'd0, rd); check("r_status_empty", rd, 8'h00);
    r_read(4'd1, rd); check("head_empty", rd, 8'h00);

    // Overflow on the fifth push, then clear it
    for (int i = 1; i <= 4; i++) a_write(4'd1, 8'(i));
    a_read(4'd0, rd); check("status_full", rd, 8'h44);
    a_write(4'd1, 8'h05);
    a_read(4'd0, rd); check("status_overflow", rd, 8'hC4);
    a_write(4'd0, 8'h04);
    a_read(4'd0, rd); check("status_ovf_clr", rd, 8'h44);
    r_read(4'd1, rd); check("head_first", rd, 8'h81);

    // Push and pop together on a full queue
    push_pop(8'h06);
    a_read(4'd0, rd); check("full_push_pop", rd, 8'h44);
    r_write(4'd1, 8'h00); r_read(4'd1, rd); check("head_after_pop1", rd, 8'h83);
    r_write(4'd1, 8'h00); r_read(4'd1, rd); check("head_after_pop2", rd, 8'h84);
    r_write(4'd1, 8'h00); r_read(4'd1, rd); check("head_tail_new", rd, 8'h86);
    r_write(4'd1, 8'h00); r_read(4'd1, rd); check("head_drained", rd, 8'h00);
    r_write(4'd1, 8'h00); r_read(4'd0, rd); check("pop_on_empty", rd, 8'h00);

    // Push and pop together on an empty queue
    push_pop(8'h07);
    a_read(4'd0, rd); check("empty_push_pop", rd, 8'h01);
    r_read(4'd1, rd); check("empty_pp_head", rd, 8'h87);
    r_read(4'd2, rd); check("empty_pp_pay0", rd, 8'h34);

    // Reply path
    a_write(4'd0, 8'h02);
    r_write(4'd2, 8'hAA);
    r_write(4'd3, 8'h55);
    r_write(4'hF, 8'h00);
    check("a_irq_post", {7'd0, a_irq}, {7'd0, EXP_A_IRQ});
    a_read(4'd2, rd); check("reply0", rd, 8'hAA);
    a_read(4'd3, rd); check("reply1", rd, 8'h55);
    a_read(4'd0, rd); check("a_status_rv", rd, 8'h21);
    r_read(4'd0, rd); check("r_status_rv", rd, 8'hC1);
    @(negedge C7M);
    a_addr = 4'hE; a_wr = 1'b1; r_addr = 4'hF; r_wr = 1'b1;
    @(negedge C7M); a_wr = 1'b0; r_wr = 1'b0;
    a_read(4'd0, rd); check("post_ack_same", rd, 8'h21);
    a_write(4'hE, 8'h00);
    a_read(4'd0, rd); check("ack_clears", rd, 8'h01);
    check("a_irq_acked", {7'd0, a_irq}, 8'h00);
    a_read(4'd4, rd); check("a_unmapped", rd, 8'h00);
    r_read(4'd4, rd); check("r_unmapped", rd, 8'h00);
    check("a_dout_held", a_dout, 8'h00);

    // Reset mid-operation
    a_write(4'd1, 8'h08);
    a_write(4'd1, 8'h09);
    a_write(4'd0, 8'h01);
    a_read(4'd0, rd); check("pre_reset_status", rd, 8'h03);
    check("avr_rst_set", {7'd0, avr_rst}, 8'h01);
    @(negedge C7M); RES = 1'b1;
    @(negedge C7M); RES = 1'b0;
    check("post_reset_avr_rst", {7'd0, avr_rst}, 8'h00);
    check("post_reset_avr_irq", {7'd0, avr_irq}, 8'h00);
    check("post_reset_a_dout", a_dout, 8'h00);
    r_read(4'd1, rd); check("post_reset_head", rd, 8'h00);
    a_read(4'd0, rd); check("post_reset_status", rd, 8'h00);
    a_write(4'd1, 8'h0A);
    r_read(4'd2, rd); check("post_reset_staging", rd, 8'h00);
    r_read(4'd1, rd); check("post_reset_push", rd, 8'h8A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mbox_queue.md
# mbox_queue

Parametrised host/coprocessor mailbox: the next generation of the card's shared command/data register file. The 6502 side stages a DATA_BYTES-wide payload and submits 7-bit commands into a CMDQ_DEPTH-entry FIFO. The AVR side consumes entries and posts replies back through a single reply buffer. Bus decode and select-strobe generation sit upstream; this block sees only single-cycle, C7M-synchronous strobes.

## Interface
Parameters:
- DATA_BYTES, 2: payload bytes per command/reply, 1..8
- CMDQ_DEPTH, 4: command FIFO entries, power of two, 2..16

Ports:
- C7M  in  1  sole clock, all logic on rising edge
- RES  in  1  reset; synchronous, active-high
- a_addr  in  4  6502 register select
- a_wr  in  1  6502 write strobe, one cycle per access
- a_rd  in  1  6502 read strobe, one cycle per access
- a_din  in  8  6502 write data
- a_dout  out  8  6502 read data, registered
- r_addr  in  4  AVR register select
- r_wr  in  1  AVR write strobe
- r_rd  in  1  AVR read strobe
- r_din  in  8  AVR write data
- r_dout  out  8  AVR read data, registered
- avr_irq  out  1  AVR interrupt, active-high
- a_irq  out  1  6502 interrupt, active-high
- avr_rst  out  1  AVR reset request, active-high

## Operation
6502 map:
- 0 read: {overflow, full, reply_valid, count[4:0] zero-extended}
- 0 write: bit2=1 clears overflow; bit1 → a_irq_en; bit0 → avr_rst
- 1 write: push {a_din[6:0], staging}
- 2..2+DATA_BYTES-1 write: staging byte (addr-2); read: reply byte (addr-2)
- 0xE write: acknowledge, clears reply_valid
- Unmapped reads return 0x00; unmapped writes are ignored.

AVR map:
- 0 read: {~empty, reply_valid, 1'b0, count[4:0]}
- 0 write: bit0 → avr_irq_en
- 1 read: {~empty, head cmd[6:0]}; 1 write: pop
- 2..2+DATA_BYTES-1 read: head payload byte; write: reply byte
- 0xF write: post reply, sets reply_valid
- When the FIFO is empty, head reads return 0x00.

Behaviour:
- count width $clog2(CMDQ_DEPTH+1); read/write pointers wrap modulo CMDQ_DEPTH.
- Push when full and no pop in the same cycle: entry dropped, overflow set (sticky).
- Pop when empty: ignored.
- Simultaneous push+pop when full: both execute, count unchanged.
- Simultaneous push+pop when empty: push executes, pop ignored.
- A push captures staging as it stood before any same-cycle staging write.
- Post while reply_valid is already set: reply bytes are overwritten.
- Post and ack in the same cycle: post wins, reply_valid=1.
- avr_irq = avr_irq_en & ~empty.

## Timing
- a_dout/r_dout update on the edge where the rd strobe is sampled; valid next cycle and held until the next rd.
- Register/FIFO state changes on the strobe edge; status reads in the following cycle reflect it.
- Push-to-AVR visibility: 1 cycle. avr_irq asserts 1 cycle after the push strobe.
- Reset: all outputs 0; count=0; pointers=0; staging, reply, overflow, reply_valid, both irq enables and avr_rst cleared. Reset mid-operation discards queued entries.

## Configuration
- MBOX_REPLY_IRQ_EN defined: a_irq = a_irq_en & reply_valid.
- Undefined: a_irq tied 0, a_irq_en storage omitted; status bit1 writes are ignored; reply_valid remains pollable.

## Test plan
- Reset, then read 6502 addr 0 → 0x00; avr_rst=0, avr_irq=0.
- DATA_BYTES=2: stage 0x34,0x12 and push cmd 0x05; AVR reads addr1 → 0x85, addr2 → 0x34, addr3 → 0x12; pop; AVR status → 0x00.
- CMDQ_DEPTH=4: push 5 commands without pops → 5th dropped, 6502 status 0xC4; write 0x04 to addr 0 → status 0x44.
- Full queue with push and pop in the same cycle → count stays 4, overflow stays 0, new entry at the tail.
- With MBOX_REPLY_IRQ_EN and a_irq_en=1: AVR writes 0xAA at addr2, posts → a_irq=1, 6502 read addr2 → 0xAA; post and ack in the same cycle → reply_valid=1.
- Assert RES with 3 queued entries and avr_rst=1 → next cycle count=0, avr_rst=0, r_dout on addr1 read → 0x00.
